// File: rtl/regfile_wb.sv
// Write-back arbiter for the regfile write port: ALU results have priority, byte loads wait in a
// DEPTH-entry queue, and queued loads raise a load-use hazard. Optional stats: REGFILE_WB_STATS_EN.
module regfile_wb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic        alu_word,
    input  logic [5:0]  alu_d,
    input  logic [15:0] alu_Rd,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [5:0]  ld_d,
    input  logic [7:0]  ld_data,
    input  logic [5:0]  rd_a,
    input  logic        rd_a_word,
    input  logic [5:0]  rd_b,
    output logic        hazard,
    output logic        write,
    output logic        write_word,
    output logic [5:0]  d,
    output logic [15:0] Rd,
    output logic        misalign,
    output logic [15:0] stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [5:0]       q_d    [DEPTH];
    logic [7:0]       q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             q_empty;
    logic             accept;
    logic             pop;
    logic             push;
    logic             bypass;

    assign q_empty  = (count == '0);
    assign ld_ready = (count != FULL_CNT) && !reset;
    assign accept   = ld_valid && ld_ready;
    assign pop      = !alu_valid && !q_empty;
    // A load arriving at an idle, empty queue goes straight to the write port.
    assign bypass   = accept && !alu_valid && q_empty;
    assign push     = accept && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            q_d[tail]    <= ld_d;
            q_data[tail] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            if (push) begin
                tail          <= tail + 1'b1;
                q_valid[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + 1'b1;
                q_valid[head] <= 1'b0;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write      <= 1'b0;
            write_word <= 1'b0;
            d          <= '0;
            Rd         <= '0;
            misalign   <= 1'b0;
        end else begin
            write      <= alu_valid || pop || bypass;
            write_word <= 1'b0;
            if (alu_valid) begin
                write_word <= alu_word;
                d          <= alu_word ? {alu_d[5:1], 1'b0} : alu_d;
                Rd         <= alu_word ? alu_Rd : {8'h00, alu_Rd[7:0]};
                if (alu_word && alu_d[0])
                    misalign <= 1'b1;
            end else if (pop) begin
                d  <= q_d[head];
                Rd <= {8'h00, q_data[head]};
            end else if (bypass) begin
                d  <= ld_d;
                Rd <= {8'h00, ld_data};
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_d[i] == rd_b || q_d[i] == rd_a ||
                               (rd_a_word && q_d[i] == {rd_a[5:1], 1'b1})))
                hazard = 1'b1;
        end
    end

`ifdef REGFILE_WB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if (alu_valid && !q_empty && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: a reference model predicts each cycle's write and queue state.
module tb_regfile_wb;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_word, ld_valid, rd_a_word;
    logic [5:0]  alu_d, ld_d, rd_a, rd_b;
    logic [15:0] alu_Rd;
    logic [7:0]  ld_data;
    logic        ld_ready, hazard, write, write_word, misalign;
    logic [5:0]  d;
    logic [15:0] Rd, stall_cnt;

    regfile_wb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_word(alu_word), .alu_d(alu_d), .alu_Rd(alu_Rd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_d(ld_d), .ld_data(ld_data),
        .rd_a(rd_a), .rd_a_word(rd_a_word), .rd_b(rd_b), .hazard(hazard),
        .write(write), .write_word(write_word), .d(d), .Rd(Rd),
        .misalign(misalign), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic        ww;
        logic [5:0]  d;
        logic [15:0] rd;
    } exp_t;

    typedef struct packed {
        logic [5:0] d;
        logic [7:0] data;
    } ld_t;

    exp_t        sb[$];
    ld_t         mq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        exp_mis = 1'b0;
    logic [15:0] exp_stall = 16'h0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic model_hazard(logic [5:0] a, logic aw, logic [5:0] b);
        foreach (mq[i])
            if (mq[i].d == b || mq[i].d == a || (aw && mq[i].d == {a[5:1], 1'b1}))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        check("write", write, e.w);
        if (e.w) begin
            check("write_word", write_word, e.ww);
            check("d", d, e.d);
            check("Rd", Rd, e.rd);
        end
        check("misalign", misalign, exp_mis);
        check("stall_cnt", stall_cnt, exp_stall);
    endtask

    // Drive one cycle at the falling edge, predict, then compare after the rising edge.
    task automatic step(logic av, logic aw, logic [5:0] ad, logic [15:0] ard,
                        logic lv, logic [5:0] ldd, logic [7:0] ldat,
                        logic [5:0] ra, logic raw, logic [5:0] rb);
        exp_t e;
        ld_t  h;
        logic rdy, acc, was_empty, byp;
        alu_valid = av; alu_word = aw; alu_d = ad; alu_Rd = ard;
        ld_valid = lv; ld_d = ldd; ld_data = ldat;
        rd_a = ra; rd_a_word = raw; rd_b = rb;
        #1;
        rdy = (mq.size() != DEPTH);
        check("ld_ready", ld_ready, rdy);
        check("hazard", hazard, model_hazard(ra, raw, rb));
        acc = lv && rdy;
        was_empty = (mq.size() == 0);
        byp = acc && !av && was_empty;
`ifdef REGFILE_WB_STATS_EN
        if (av && !was_empty && exp_stall != 16'hFFFF)
            exp_stall = exp_stall + 16'd1;
`endif
        e = '0;
        if (av) begin
            e.w  = 1'b1;
            e.ww = aw;
            e.d  = aw ? {ad[5:1], 1'b0} : ad;
            e.rd = aw ? ard : {8'h00, ard[7:0]};
            if (aw && ad[0])
                exp_mis = 1'b1;
        end else if (!was_empty) begin
            h    = mq.pop_front();
            e.w  = 1'b1;
            e.d  = h.d;
            e.rd = {8'h00, h.data};
        end else if (byp) begin
            e.w  = 1'b1;
            e.d  = ldd;
            e.rd = {8'h00, ldat};
        end
        if (acc && !byp) begin
            h.d = ldd;
            h.data = ldat;
            mq.push_back(h);
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(logic [5:0] rb);
        step(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 8'h0, 6'd63, 1'b0, rb);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 1'b0; alu_word = 1'b0; alu_d = '0; alu_Rd = '0;
        ld_valid = 1'b0; ld_d = '0; ld_data = '0;
        rd_a = 6'd63; rd_a_word = 1'b0; rd_b = 6'd63;
        #1;
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_write", write, 1'b0);
        check("rst_write_word", write_word, 1'b0);
        check("rst_d", d, 6'd0);
        check("rst_Rd", Rd, 16'h0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_write_held", write, 1'b0);
        check("rst_ld_ready_held", ld_ready, 1'b0);
        reset = 1'b0;
        mq.delete();
        sb.delete();
        exp_mis = 1'b0;
        exp_stall = 16'h0;
    endtask

    initial begin
        do_reset();

        // ALU byte write
        step(1'b1, 1'b0, 6'd5, 16'h12AB, 1'b0, 6'd0, 8'h0, 6'd63, 1'b0, 6'd63);
        check("alu_byte_Rd", Rd, 16'h00AB);

        // bypass load never raises hazard
        step(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd3, 8'h7E, 6'd3, 1'b0, 6'd3);
        check("bypass_d", d, 6'd3);
        check("bypass_hazard", hazard, 1'b0);

        // fill the queue under ALU pressure, then drain
        step(1'b1, 1'b0, 6'd1, 16'h0011, 1'b1, 6'd10, 8'hA0, 6'd63, 1'b0, 6'd10);
        step(1'b1, 1'b0, 6'd2, 16'h0022, 1'b1, 6'd11, 8'hB1, 6'd63, 1'b0, 6'd10);
        step(1'b1, 1'b0, 6'd4, 16'h0044, 1'b1, 6'd12, 8'hC2, 6'd63, 1'b0, 6'd10);
        check("full_ld_ready", ld_ready, 1'b0);
        check("full_hazard", hazard, 1'b1);
        idle(6'd10);
        check("drain_r10", d, 6'd10);
        idle(6'd11);
        check("drain_r11", d, 6'd11);
        idle(6'd11);
        check("drained_hazard", hazard, 1'b0);

        // word write to an odd register pair
        step(1'b1, 1'b1, 6'd25, 16'hBEEF, 1'b0, 6'd0, 8'h0, 6'd63, 1'b0, 6'd63);
        check("word_d", d, 6'd24);
        check("word_misalign", misalign, 1'b1);
        idle(6'd63);
        idle(6'd63);

        // pair read on rd_a hits queued odd half
        step(1'b1, 1'b0, 6'd2, 16'h0002, 1'b1, 6'd13, 8'h55, 6'd12, 1'b1, 6'd63);
        step(1'b1, 1'b0, 6'd2, 16'h0002, 1'b0, 6'd0, 8'h0, 6'd12, 1'b1, 6'd63);
        check("pair_hazard", hazard, 1'b1);
        idle(6'd63);

        // randomised traffic on a small register range
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                 16'($urandom), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                 8'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 1; i++)
            idle(6'd63);

        // starvation counter
        do_reset();
        step(1'b1, 1'b0, 6'd7, 16'h0007, 1'b1, 6'd20, 8'h20, 6'd63, 1'b0, 6'd63);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 6'd7, 16'h0007, 1'b0, 6'd0, 8'h0, 6'd63, 1'b0, 6'd63);
`ifdef REGFILE_WB_STATS_EN
        check("stall_five", stall_cnt, 16'd5);
`else
        check("stall_tied", stall_cnt, 16'd0);
`endif
        idle(6'd63);

        // reset with two loads queued
        step(1'b1, 1'b0, 6'd8, 16'h0008, 1'b1, 6'd30, 8'h30, 6'd63, 1'b0, 6'd63);
        step(1'b1, 1'b0, 6'd8, 16'h0008, 1'b1, 6'd31, 8'h31, 6'd63, 1'b0, 6'd30);
        check("pre_reset_hazard", hazard, 1'b1);
        do_reset();
        idle(6'd30);
        check("post_reset_write", write, 1'b0);
        idle(6'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
